// File: rtl/vga_timing_pkg.sv
// Shared raster constants and types for the VGA timing generator.
// Defaults describe 640x480@60 Hz from a 100 MHz system clock.
package vga_timing_pkg;

  localparam int CW      = 11;
  localparam int CNT_MAX = (1 << CW) - 1;

  typedef logic [CW-1:0] count_t;

  localparam int DEF_CLK_DIV  = 4;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  function automatic int axis_total(input int active, input int fp, input int sync,
                                    input int bp);
    return active + fp + sync + bp;
  endfunction

  localparam int DEF_H_TOTAL = axis_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int DEF_V_TOTAL = axis_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with registered sync decode.
// active_next reports whether the position after this edge lies in the visible region.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE   = DEF_H_ACTIVE,
  parameter int FP       = DEF_H_FP,
  parameter int SYNC     = DEF_H_SYNC,
  parameter int BP       = DEF_H_BP,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          advance,
  output logic [CW-1:0] count,
  output logic          at_end,
  output logic          active_next,
  output logic          sync
);

  localparam int     TOTAL    = axis_total(ACTIVE, FP, SYNC, BP);
  localparam count_t LAST     = count_t'(TOTAL - 1);
  localparam count_t ACT_END  = count_t'(ACTIVE);
  localparam count_t SYNC_BEG = count_t'(ACTIVE + FP);
  localparam count_t SYNC_END = count_t'(ACTIVE + FP + SYNC);

  if (TOTAL > CNT_MAX) begin : g_total_check
    $error("vga_axis_counter: axis total exceeds the 11-bit count range");
  end

  count_t count_nxt;
  count_t count_upd;
  logic   sync_nxt;

  assign at_end      = (count == LAST);
  assign count_nxt   = at_end ? '0 : count + count_t'(1);
  assign count_upd   = advance ? count_nxt : count;
  assign active_next = (count_upd < ACT_END);
  assign sync_nxt    = ((count_nxt >= SYNC_BEG) && (count_nxt < SYNC_END)) ? SYNC_POL : ~SYNC_POL;

  // sync is decoded from the incoming position so it never lags the count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      sync  <= ~SYNC_POL;
    end else if (advance) begin
      count <= count_nxt;
      sync  <= sync_nxt;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster scan generator: pixel prescaler, H/V axis counters and aligned strobes.
// Every output is registered on the same edge that moves (hcount, vcount).
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          enable,
  output logic          pix_en,
  output logic [CW-1:0] hcount,
  output logic [CW-1:0] vcount,
  output logic          blank,
  output logic          hsync,
  output logic          vsync,
  output logic          line_start,
  output logic          frame_start
);

  localparam int            PW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

  if (CLK_DIV < 1) begin : g_div_check
    $error("vga_timing_gen: CLK_DIV must be at least 1");
  end

  logic [PW-1:0] presc;
  logic          tick;
  logic          h_at_end;
  logic          v_at_end;
  logic          h_active_next;
  logic          v_active_next;

  assign tick = enable && (presc == PRESC_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc <= '0;
    end else if (enable) begin
      presc <= tick ? '0 : presc + PW'(1);
    end
  end

  vga_axis_counter #(
    .ACTIVE   (H_ACTIVE),
    .FP       (H_FP),
    .SYNC     (H_SYNC),
    .BP       (H_BP),
    .SYNC_POL (SYNC_POL)
  ) u_h_axis (
    .clk         (clk),
    .reset_n     (reset_n),
    .advance     (tick),
    .count       (hcount),
    .at_end      (h_at_end),
    .active_next (h_active_next),
    .sync        (hsync)
  );

  vga_axis_counter #(
    .ACTIVE   (V_ACTIVE),
    .FP       (V_FP),
    .SYNC     (V_SYNC),
    .BP       (V_BP),
    .SYNC_POL (SYNC_POL)
  ) u_v_axis (
    .clk         (clk),
    .reset_n     (reset_n),
    .advance     (tick && h_at_end),
    .count       (vcount),
    .at_end      (v_at_end),
    .active_next (v_active_next),
    .sync        (vsync)
  );

  // tick already carries enable, so strobes drop to 0 while frozen
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_en      <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      blank       <= 1'b0;
    end else begin
      pix_en      <= tick;
      line_start  <= tick && h_at_end;
      frame_start <= tick && h_at_end && v_at_end;
      if (tick) begin
        blank <= ~(h_active_next && v_active_next);
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 instance plus a tiny-geometry instance
// (CLK_DIV=1, active-high syncs) that wraps whole frames quickly.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic enable = 1'b1;

  always #5 clk = ~clk;

  logic        pix_en, blank, hsync, vsync, line_start, frame_start;
  logic [10:0] hcount, vcount;
  logic        s_pix_en, s_blank, s_hsync, s_vsync, s_line_start, s_frame_start;
  logic [10:0] s_hcount, s_vcount;

  vga_timing_gen dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .pix_en(pix_en),
    .hcount(hcount), .vcount(vcount), .blank(blank), .hsync(hsync), .vsync(vsync),
    .line_start(line_start), .frame_start(frame_start)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b1)
  ) dut_s (
    .clk(clk), .reset_n(reset_n), .enable(enable), .pix_en(s_pix_en),
    .hcount(s_hcount), .vcount(s_vcount), .blank(s_blank), .hsync(s_hsync), .vsync(s_vsync),
    .line_start(s_line_start), .frame_start(s_frame_start)
  );

  typedef struct packed {
    logic        pix_en;
    logic [10:0] h;
    logic [10:0] v;
    logic        blank;
    logic        hsync;
    logic        vsync;
    logic        ls;
    logic        fs;
  } exp_t;

  int checks = 0;
  int failures = 0;
  int n = 0;        // enabled clk edges since reset release
  bit last_en = 1'b0;
  int en_l = 0;
  int en_f = 0;

  // Raster position is just the enabled-edge count divided down by the pixel and line sizes.
  function automatic exp_t model(input int nn, input bit le, input int div,
                                 input int ha, input int hf, input int hs, input int hb,
                                 input int va, input int vf, input int vs, input int vb,
                                 input bit pol);
    exp_t e;
    int ht, vt, pix, h, v;
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    pix = nn / div;
    h = pix % ht;
    v = (pix / ht) % vt;
    e.h = 11'(h);
    e.v = 11'(v);
    e.pix_en = le && (nn > 0) && (nn % div == 0);
    e.ls = e.pix_en && (h == 0);
    e.fs = e.ls && (v == 0);
    e.blank = (h >= ha) || (v >= va);
    e.hsync = (h >= ha + hf && h < ha + hf + hs) ? pol : !pol;
    e.vsync = (v >= va + vf && v < va + vf + vs) ? pol : !pol;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_all();
    exp_t e, o;
    e = model(n, last_en, 4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
    o.pix_en = pix_en; o.h = hcount; o.v = vcount; o.blank = blank;
    o.hsync = hsync; o.vsync = vsync; o.ls = line_start; o.fs = frame_start;
    chk("big_outputs", o, e);
    e = model(n, last_en, 1, 8, 2, 3, 2, 4, 1, 2, 1, 1'b1);
    o.pix_en = s_pix_en; o.h = s_hcount; o.v = s_vcount; o.blank = s_blank;
    o.hsync = s_hsync; o.vsync = s_vsync; o.ls = s_line_start; o.fs = s_frame_start;
    chk("small_outputs", o, e);
  endtask

  task automatic cyc(input bit en);
    enable = en;
    @(posedge clk);
    if (reset_n) begin
      if (en) begin
        n++; en_l++; en_f++;
      end
      last_en = en;
    end
    #1;
    check_all();
    if (line_start) begin
      chk("line_period", en_l, 3200);
      en_l = 0;
    end
    if (s_frame_start) begin
      chk("small_frame_period", en_f, 120);
      en_f = 0;
    end
  endtask

  initial begin
    bit found;
    int hs_low;
    int first_blank_h;

    // reset held with enable high: reset values, no counting
    #12;
    check_all();
    chk("rst_hsync", hsync, 1);
    chk("rst_small_hsync", s_hsync, 0);
    cyc(1'b1);
    chk("rst_hold_h", hcount, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // hcount 0->1 on the 4th edge, pix_en 1,0,0,0
    cyc(1'b1); cyc(1'b1); cyc(1'b1);
    chk("t1_h_after3", hcount, 0);
    chk("t1_pix_after3", pix_en, 0);
    cyc(1'b1);
    chk("t1_h_after4", hcount, 1);
    chk("t1_pix_after4", pix_en, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1);
      chk("t1_pix_gap", pix_en, 0);
    end
    cyc(1'b1);
    chk("t1_h_after8", hcount, 2);
    chk("t1_pix_after8", pix_en, 1);

    // scan to (799,5) while measuring line 0 blank/hsync
    found = 1'b0;
    hs_low = 0;
    first_blank_h = -1;
    for (int i = 0; i < 25000 && !found; i++) begin
      cyc(1'b1);
      if (vcount == 0 && !hsync) hs_low++;
      if (vcount == 0 && blank && first_blank_h < 0) first_blank_h = int'(hcount);
      if (hcount == 799 && vcount == 5) found = 1'b1;
    end
    chk("t2_reached_799_5", found, 1);
    chk("t3_hsync_low_clks", hs_low, 384);
    chk("t3_blank_rise_h", first_blank_h, 640);
    cyc(1'b1); cyc(1'b1); cyc(1'b1);
    chk("t2_h_hold", hcount, 799);
    chk("t2_ls_early", line_start, 0);
    cyc(1'b1);
    chk("t2_h_wrap", hcount, 0);
    chk("t2_v_inc", vcount, 6);
    chk("t2_line_start", line_start, 1);
    chk("t2_frame_start", frame_start, 0);
    cyc(1'b1);
    chk("t2_ls_one_clk", line_start, 0);

    // freeze at hcount=100 right after its pix_en
    found = 1'b0;
    for (int i = 0; i < 4000 && !found; i++) begin
      cyc(1'b1);
      if (hcount == 100 && pix_en) found = 1'b1;
    end
    chk("t5_reached_100", found, 1);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0);
      chk("t5_h_frozen", hcount, 100);
      chk("t5_no_pix", pix_en, 0);
    end
    cyc(1'b1); cyc(1'b1); cyc(1'b1);
    chk("t5_h_resume3", hcount, 100);
    cyc(1'b1);
    chk("t5_h_resume4", hcount, 101);
    chk("t5_pix_resume4", pix_en, 1);

    // random enable gating
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 3) != 0);
    end

    // async reset mid-line, between clk edges
    found = 1'b0;
    for (int i = 0; i < 4000 && !found; i++) begin
      cyc(1'b1);
      if (hcount == 300) found = 1'b1;
    end
    chk("t6_reached_300", found, 1);
    #2;
    reset_n = 1'b0;
    n = 0; last_en = 1'b0; en_l = 0; en_f = 0;
    #1;
    check_all();
    chk("t6_async_h", hcount, 0);
    chk("t6_async_hsync", hsync, 1);
    cyc(1'b1);
    @(negedge clk);
    reset_n = 1'b1;
    cyc(1'b1); cyc(1'b1); cyc(1'b1);
    chk("t6_h_after3", hcount, 0);
    cyc(1'b1);
    chk("t6_h_after4", hcount, 1);
    for (int i = 0; i < 200; i++) begin
      cyc(1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
